// File: rtl/multicycle_alu_datapath.sv
// rtl/multicycle_alu_datapath.sv - multi-cycle RV R/I-type ALU datapath with fetch handshake
// FETCH -> DECODE -> EXECUTE -> WRITEBACK per instruction; illegal encodings park in TRAP until rst.
module multicycle_alu_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instrReq,
  output logic [XLEN-1:0] instrMemAddr,
  input  logic            instrValid,
  input  logic [31:0]     instrCode,
  output logic            retire,
  output logic            illegal,
  input  logic [4:0]      dbgAddr,
  output logic [XLEN-1:0] dbgData
);
  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned SW = (XLEN == 64) ? 6 : 5;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_SLL = 4'd4, ALU_SRL = 4'd5, ALU_SRA = 4'd6, ALU_SLT = 4'd7,
                         ALU_SLTU = 4'd8, ALU_XOR = 4'd9;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP} state_t;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_y;
  logic [31:0]     r_ir;
  logic [4:0]      r_rd;
  logic [3:0]      r_ctrl;
  logic [XLEN-1:0] r_regs [NREGS];

  logic [6:0]      w_opcode, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_is_r, w_legal, w_op_ok, w_regs_bad, w_sh_ok;
  logic [3:0]      w_ctrl;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_y;
  logic [SW-1:0]   w_shamt;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];
  assign w_imm    = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  // imm[5] is the top shamt bit, only meaningful when XLEN = 64
  assign w_sh_ok  = (XLEN == 64) || !r_ir[25];

  assign w_rs1_val = (w_rs1 == 5'd0 || 32'(w_rs1) >= NREGS) ? '0 : r_regs[w_rs1[RW-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0 || 32'(w_rs2) >= NREGS) ? '0 : r_regs[w_rs2[RW-1:0]];
  assign dbgData   = (dbgAddr == 5'd0 || 32'(dbgAddr) >= NREGS) ? '0 : r_regs[dbgAddr[RW-1:0]];
  assign instrMemAddr = r_pc;

  assign w_regs_bad = (32'(w_rs1) >= NREGS) || (32'(w_rd) >= NREGS) ||
                      (w_is_r && 32'(w_rs2) >= NREGS);
  assign w_legal    = w_op_ok && !w_regs_bad;

  always_comb begin
    w_is_r  = 1'b0;
    w_op_ok = 1'b0;
    w_ctrl  = ALU_ADD;
    if (w_opcode == 7'b0110011) begin
      w_is_r = 1'b1;
      case (w_f3)
        3'b000: begin
          if (w_f7 == 7'b0000000) begin w_op_ok = 1'b1; w_ctrl = ALU_ADD; end
          else if (w_f7 == 7'b0100000) begin w_op_ok = 1'b1; w_ctrl = ALU_SUB; end
        end
        3'b001: begin w_op_ok = (w_f7 == 7'b0000000); w_ctrl = ALU_SLL;  end
        3'b010: begin w_op_ok = (w_f7 == 7'b0000000); w_ctrl = ALU_SLT;  end
        3'b011: begin w_op_ok = (w_f7 == 7'b0000000); w_ctrl = ALU_SLTU; end
        3'b100: begin w_op_ok = (w_f7 == 7'b0000000); w_ctrl = ALU_XOR;  end
        3'b101: begin
          if (w_f7 == 7'b0000000) begin w_op_ok = 1'b1; w_ctrl = ALU_SRL; end
          else if (w_f7 == 7'b0100000) begin w_op_ok = 1'b1; w_ctrl = ALU_SRA; end
        end
        3'b110: begin w_op_ok = (w_f7 == 7'b0000000); w_ctrl = ALU_OR;  end
        default: begin w_op_ok = (w_f7 == 7'b0000000); w_ctrl = ALU_AND; end
      endcase
    end else if (w_opcode == 7'b0010011) begin
      case (w_f3)
        3'b000: begin w_op_ok = 1'b1; w_ctrl = ALU_ADD;  end
        3'b010: begin w_op_ok = 1'b1; w_ctrl = ALU_SLT;  end
        3'b011: begin w_op_ok = 1'b1; w_ctrl = ALU_SLTU; end
        3'b100: begin w_op_ok = 1'b1; w_ctrl = ALU_XOR;  end
        3'b110: begin w_op_ok = 1'b1; w_ctrl = ALU_OR;   end
        3'b111: begin w_op_ok = 1'b1; w_ctrl = ALU_AND;  end
        3'b001: begin w_op_ok = (r_ir[31:26] == 6'b000000) && w_sh_ok; w_ctrl = ALU_SLL; end
        default: begin
          if (r_ir[31:26] == 6'b000000) begin w_op_ok = w_sh_ok; w_ctrl = ALU_SRL; end
          else if (r_ir[31:26] == 6'b010000) begin w_op_ok = w_sh_ok; w_ctrl = ALU_SRA; end
        end
      endcase
    end
  end

  assign w_shamt = r_b[SW-1:0];

  always_comb begin
    w_y = r_a + r_b;
    case (r_ctrl)
      ALU_SUB:  w_y = r_a - r_b;
      ALU_AND:  w_y = r_a & r_b;
      ALU_OR:   w_y = r_a | r_b;
      ALU_SLL:  w_y = r_a << w_shamt;
      ALU_SRL:  w_y = r_a >> w_shamt;
      ALU_SRA:  w_y = $unsigned($signed(r_a) >>> w_shamt);
      ALU_SLT:  w_y = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      ALU_SLTU: w_y = {{(XLEN-1){1'b0}}, (r_a < r_b)};
      ALU_XOR:  w_y = r_a ^ r_b;
      default:  w_y = r_a + r_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    instrReq = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        instrReq = 1'b1;
        if (instrValid) w_next = S_DECODE;
      end
      S_DECODE:    w_next = w_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: begin retire = 1'b1; w_next = S_FETCH; end
      S_TRAP:      illegal = 1'b1;
      default:     w_next = S_FETCH;
    endcase
    if (rst) begin
      instrReq = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_ir   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_y    <= '0;
      r_rd   <= '0;
      r_ctrl <= ALU_ADD;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (instrValid) r_ir <= instrCode;
        S_DECODE: if (w_legal) begin
          r_a    <= w_rs1_val;
          r_b    <= w_is_r ? w_rs2_val : w_imm;
          r_rd   <= w_rd;
          r_ctrl <= w_ctrl;
        end
        S_EXECUTE: r_y <= w_y;
        S_WRITEBACK: begin
          if (r_rd != 5'd0) r_regs[r_rd[RW-1:0]] <= r_y;
          r_pc <= r_pc + XLEN'(PC_STEP);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu_datapath.sv
// tb/tb_multicycle_alu_datapath.sv - scoreboard bench for multicycle_alu_datapath
// Stimulus pushes expected {pc, rd, value} per retiring instruction; a monitor checks on retire.
module tb_multicycle_alu_datapath;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instrValid, instrReq, retire, illegal;
  logic [31:0] instrCode, instrMemAddr, dbgData;
  logic [4:0]  dbgAddr;

  logic        rst64, v64, req64, ret64, ill64;
  logic [31:0] code64;
  logic [63:0] addr64, data64;
  logic [4:0]  dbg64;

  multicycle_alu_datapath dut (
    .clk(clk), .rst(rst), .instrReq(instrReq), .instrMemAddr(instrMemAddr),
    .instrValid(instrValid), .instrCode(instrCode), .retire(retire), .illegal(illegal),
    .dbgAddr(dbgAddr), .dbgData(dbgData)
  );

  multicycle_alu_datapath #(.XLEN(64), .NREGS(16)) dut64 (
    .clk(clk), .rst(rst64), .instrReq(req64), .instrMemAddr(addr64),
    .instrValid(v64), .instrCode(code64), .retire(ret64), .illegal(ill64),
    .dbgAddr(dbg64), .dbgData(data64)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [31:0] code;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          hold;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!instrReq && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instrReq) check("fetch_timeout", instrReq, 1);
  endtask

  task automatic issue(input logic [31:0] code, input logic [4:0] rd, input logic [31:0] val,
                       input bit push, input bit hold);
    wait_req();
    check("fetch_pc", instrMemAddr, exp_pc);
    instrValid = 1'b1;
    instrCode  = code;
    if (push) sb.push_back('{pc: exp_pc, rd: rd, val: val});
    @(posedge clk); #1;
    if (hold) begin
      instrCode = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    instrValid = 1'b0;
    instrCode  = '0;
    if (push) exp_pc += 32'd4;
  endtask

  task automatic issue64(input logic [31:0] code, input bit wait_ret);
    int n = 0;
    while (!req64 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req64) check("fetch64_timeout", req64, 1);
    v64    = 1'b1;
    code64 = code;
    @(posedge clk); #1;
    v64    = 1'b0;
    code64 = '0;
    if (wait_ret) begin
      n = 0;
      while (!ret64 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      check("retire64", ret64, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    exp_t e;
    dbgAddr = '0;
    forever begin
      @(negedge clk);
      if (retire) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", retire, 0);
        end else begin
          e = sb.pop_front();
          check("retire_pc", instrMemAddr, e.pc);
          dbgAddr = e.rd;
          @(negedge clk);
          check("retire_pulse", retire, 0);
          check($sformatf("reg_x%0d", e.rd), dbgData, e.val);
        end
      end
    end
  end

  vec_t vecs[$];

  initial begin
    int n;
    rst = 1'b1; instrValid = 1'b0; instrCode = '0;
    rst64 = 1'b1; v64 = 1'b0; code64 = '0; dbg64 = '0;
    exp_pc = '0;
    vecs = '{
      '{32'hFFD00113, 5'd2,  32'hFFFF_FFFD, 1'b0},
      '{32'h402081B3, 5'd3,  32'h0000_0008, 1'b0},
      '{32'h00112233, 5'd4,  32'h0000_0001, 1'b0},
      '{32'h001132B3, 5'd5,  32'h0000_0000, 1'b0},
      '{32'h0020F533, 5'd10, 32'h0000_0005, 1'b1},
      '{32'h0020E5B3, 5'd11, 32'hFFFF_FFFD, 1'b0},
      '{32'h0020C633, 5'd12, 32'hFFFF_FFF8, 1'b0},
      '{32'h001096B3, 5'd13, 32'h0000_00A0, 1'b0},
      '{32'h00115733, 5'd14, 32'h07FF_FFFF, 1'b0},
      '{32'h40115313, 5'd6,  32'hFFFF_FFFE, 1'b0},
      '{32'h01C15393, 5'd7,  32'h0000_000F, 1'b0},
      '{32'h00700013, 5'd0,  32'h0000_0000, 1'b0}
    };

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", instrReq, 0);
    check("rst_retire", retire, 0);
    check("rst_illegal", illegal, 0);
    check("rst_pc", instrMemAddr, 32'h0);
    rst = 1'b0; rst64 = 1'b0;

    issue(32'h00500093, 5'd1, 32'd5, 1'b1, 1'b0);
    n = 1;
    while (!retire && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("retire_latency", n, 3);

    foreach (vecs[i]) issue(vecs[i].code, vecs[i].rd, vecs[i].val, 1'b1, vecs[i].hold);

    wait_req();
    for (int i = 0; i < 5; i++) begin
      check("stall_req", instrReq, 1);
      check("stall_pc", instrMemAddr, exp_pc);
      @(posedge clk); #1;
    end
    issue(32'h00108093, 5'd1, 32'd6, 1'b1, 1'b0);

    issue(32'h00000073, 5'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("trap_illegal", illegal, 1);
    check("trap_req", instrReq, 0);
    check("trap_pc", instrMemAddr, exp_pc);
    repeat (3) @(posedge clk);
    #1;
    check("trap_sticky", illegal, 1);
    check("trap_pc_frozen", instrMemAddr, exp_pc);
    rst = 1'b1;
    #2;
    check("trap_rst_illegal", illegal, 0);
    check("trap_rst_req", instrReq, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pc = '0;
    check("post_trap_pc", instrMemAddr, 32'h0);
    check("post_trap_illegal", illegal, 0);

    issue(32'h00900093, 5'd1, 32'd9, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_exec_retire", retire, 0);
    check("rst_exec_pc", instrMemAddr, 32'h0);
    issue(32'h00008413, 5'd8, 32'd0, 1'b1, 1'b0);

    issue64(32'h00100093, 1'b1);
    issue64(32'h02809093, 1'b1);
    dbg64 = 5'd1;
    #1;
    check("x64_slli", data64, 64'h0000_0100_0000_0000);
    check("x64_pc", addr64, 64'd8);
    issue64(32'h001088B3, 1'b0);
    @(posedge clk); #1;
    check("x64_rd17_illegal", ill64, 1);
    check("x64_trap_req", req64, 0);
    check("x64_trap_pc", addr64, 64'd8);
    dbg64 = 5'd20;
    #1;
    check("x64_dbg_oob", data64, 64'h0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
